// File: rtl/aurora_rv_pkg.sv
// Shared RV64I constants and decode helper for the operand issue stage.
// Holds opcode, funct7 and funct3 codes plus the decoded-instruction payload.
package aurora_rv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7;
        logic              is_op;
        logic              is_shift;
        logic              legal;
    } decode_t;

    // Field extraction and legality; anything not OP/OP-IMM decodes as illegal.
    function automatic decode_t decode(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] f7;
        logic [2:0] f3;
        d        = '0;
        f7       = instr[31:25];
        f3       = instr[14:12];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        d.funct3 = f3;
        if (instr[6:0] == OPC_OP) begin
            d.is_op  = 1'b1;
            d.funct7 = instr[30];
            d.legal  = (f7 == F7_BASE) ||
                       ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
        end else if (instr[6:0] == OPC_OP_IMM) begin
            d.legal    = 1'b1;
            d.is_shift = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
            d.funct7   = (f3 == F3_SRL_SRA) && instr[30];
        end
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with x0 hardwired to zero and
// same-cycle write-to-read bypass.
module regfile_2r1w #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Writes to x0 are dropped, so the bypass must also ignore them.
    assign ra_data = (ra_addr == '0)          ? '0 :
                     (we && (wa == ra_addr))  ? wd : regs[ra_addr];
    assign rb_data = (rb_addr == '0)          ? '0 :
                     (we && (wa == rb_addr))  ? wd : regs[rb_addr];

endmodule

// File: rtl/alu_operand_issue.sv
// RV64I integer operand issue: decodes OP/OP-IMM, reads the register file,
// tracks destination hazards and presents a one-entry operand bundle to the ALU.
module alu_operand_issue #(
    parameter int unsigned XLEN = aurora_rv_pkg::XLEN,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_instr_valid,
    output logic            out_instr_ready,
    input  logic [31:0]     in_instr,
    output logic            out_alu_valid,
    input  logic            in_alu_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [4:0]      out_rd_addr,
    input  logic            in_wb_valid,
    input  logic [4:0]      in_wb_addr,
    input  logic [XLEN-1:0] in_wb_data,
    output logic            out_illegal
);

    import aurora_rv_pkg::*;

    issue_state_t    state;
    issue_state_t    state_next;
    decode_t         dec;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] op2;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            hazard;
    logic            slot_free;
    logic            accept;
    logic            issue;
    logic            consume;

    assign dec = decode(in_instr);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (dec.rs1),
        .ra_data (rs1_data),
        .rb_addr (dec.rs2),
        .rb_data (rs2_data),
        .we      (in_wb_valid),
        .wa      (in_wb_addr),
        .wd      (in_wb_data)
    );

    // A pending source being written back this cycle is resolved by the bypass.
    assign rs1_busy  = pending[dec.rs1] && !(in_wb_valid && (in_wb_addr == dec.rs1));
    assign rs2_busy  = pending[dec.rs2] && !(in_wb_valid && (in_wb_addr == dec.rs2));
    assign hazard    = dec.legal && (rs1_busy || (dec.is_op && rs2_busy));
    assign slot_free = (state == ST_EMPTY) || in_alu_ready;

    assign out_instr_ready = slot_free && !hazard;
    assign accept          = in_instr_valid && out_instr_ready;
    assign issue           = accept && dec.legal;
    assign consume         = (state == ST_FULL) && in_alu_ready;
    assign out_alu_valid   = (state == ST_FULL);

    // Operand B: register, zero-extended shift amount, or sign-extended immediate.
    always_comb begin
        op2 = '0;
        if (dec.is_op) begin
            op2 = rs2_data;
        end else if (dec.is_shift) begin
            op2 = XLEN'(in_instr[25:20]);
        end else begin
            op2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (issue) state_next = ST_FULL;
            ST_FULL:  if (in_alu_ready && !issue) state_next = ST_EMPTY;
        endcase
    end

    // Bundle only loads on a legal accept, so it holds while the ALU stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_funct3  <= '0;
            out_funct7  <= 1'b0;
            out_rd_addr <= '0;
            out_illegal <= 1'b0;
        end else begin
            out_illegal <= accept && !dec.legal;
            if (issue) begin
                out_rs1     <= rs1_data;
                out_rs2     <= op2;
                out_funct3  <= dec.funct3;
                out_funct7  <= dec.funct7;
                out_rd_addr <= dec.rd;
            end
        end
    end

    // Scoreboard: set on consume of a bundle with rd!=0, cleared on writeback; set wins.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (consume && (out_rd_addr != '0)) begin
            pend_set[out_rd_addr] = 1'b1;
        end
        if (in_wb_valid) begin
            pend_clr[in_wb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: scoreboard of expected bundles pushed
// on acceptance and compared when the ALU consumes them.
module tb_alu_operand_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_instr_valid;
    logic        out_instr_ready;
    logic [31:0] in_instr;
    logic        out_alu_valid;
    logic        in_alu_ready;
    logic [63:0] out_rs1;
    logic [63:0] out_rs2;
    logic [2:0]  out_funct3;
    logic        out_funct7;
    logic [4:0]  out_rd_addr;
    logic        in_wb_valid;
    logic [4:0]  in_wb_addr;
    logic [63:0] in_wb_data;
    logic        out_illegal;

    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    exp_t nxt_exp;
    bit   nxt_legal;
    int   total = 0;
    int   bad   = 0;

    alu_operand_issue dut (
        .clk             (clk),
        .reset           (reset),
        .in_instr_valid  (in_instr_valid),
        .out_instr_ready (out_instr_ready),
        .in_instr        (in_instr),
        .out_alu_valid   (out_alu_valid),
        .in_alu_ready    (in_alu_ready),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_funct3      (out_funct3),
        .out_funct7      (out_funct7),
        .out_rd_addr     (out_rd_addr),
        .in_wb_valid     (in_wb_valid),
        .in_wb_addr      (in_wb_addr),
        .in_wb_data      (in_wb_data),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic exp_t mk(input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [2:0] f3, input logic f7, input logic [4:0] rd);
        exp_t e;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.f3  = f3;
        e.f7  = f7;
        e.rd  = rd;
        return e;
    endfunction

    task automatic drive_ok(input logic [31:0] instr, input exp_t e);
        in_instr       = instr;
        in_instr_valid = 1'b1;
        nxt_exp        = e;
        nxt_legal      = 1'b1;
    endtask

    task automatic drive_bad(input logic [31:0] instr);
        in_instr       = instr;
        in_instr_valid = 1'b1;
        nxt_legal      = 1'b0;
    endtask

    task automatic idle();
        in_instr       = 32'h0;
        in_instr_valid = 1'b0;
        nxt_legal      = 1'b0;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [63:0] d);
        in_wb_valid = v;
        in_wb_addr  = a;
        in_wb_data  = d;
    endtask

    // One clock: score consume/accept in the low phase, return at the next negedge.
    task automatic tick();
        bit   acc;
        bit   cons;
        exp_t e;
        #1;
        acc  = in_instr_valid && out_instr_ready;
        cons = out_alu_valid && in_alu_ready;
        if (cons) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_bundle", 64'(out_rd_addr), 64'h0);
            end else begin
                e = q.pop_front();
                chk("sb_rs1",    out_rs1, e.rs1);
                chk("sb_rs2",    out_rs2, e.rs2);
                chk("sb_funct3", 64'(out_funct3), 64'(e.f3));
                chk("sb_funct7", 64'(out_funct7), 64'(e.f7));
                chk("sb_rd",     64'(out_rd_addr), 64'(e.rd));
            end
        end
        if (acc && nxt_legal) q.push_back(nxt_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        in_alu_ready = 1'b0;
        idle();
        wb(1'b0, 5'd0, 64'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid",   64'(out_alu_valid), 64'h0);
        chk("rst_illegal", 64'(out_illegal), 64'h0);
        chk("rst_rs1",     out_rs1, 64'h0);
        chk("rst_rs2",     out_rs2, 64'h0);
        chk("rst_rd",      64'(out_rd_addr), 64'h0);
        reset = 1'b0;
        #1 chk("ready_after_rst", 64'(out_instr_ready), 64'h1);

        // Seed registers through writeback.
        wb(1'b1, 5'd1, 64'd1);    tick();
        wb(1'b1, 5'd2, 64'd2);    tick();
        wb(1'b1, 5'd3, 64'h55);   tick();
        wb(1'b0, 5'd0, 64'h0);

        // ADD x3,x1,x2 with the ALU stalled.
        drive_ok(r_type(7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3), mk(64'd1, 64'd2, 3'd0, 1'b0, 5'd3));
        tick();
        chk("add_valid", 64'(out_alu_valid), 64'h1);
        chk("add_rs1",   out_rs1, 64'd1);
        chk("add_rs2",   out_rs2, 64'd2);
        chk("add_f3",    64'(out_funct3), 64'h0);
        chk("add_f7",    64'(out_funct7), 64'h0);
        chk("add_rd",    64'(out_rd_addr), 64'd3);

        // ADDI x4,x0,-16 waits while the bundle holds.
        drive_ok(i_type(12'hFF0, 5'd0, 3'd0, 5'd4), mk(64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 3'd0, 1'b0, 5'd4));
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 64'(out_instr_ready), 64'h0);
            tick();
            chk("hold_valid", 64'(out_alu_valid), 64'h1);
            chk("hold_rs1",   out_rs1, 64'd1);
            chk("hold_rs2",   out_rs2, 64'd2);
            chk("hold_rd",    64'(out_rd_addr), 64'd3);
        end
        in_alu_ready = 1'b1;
        #1 chk("ready_on_consume", 64'(out_instr_ready), 64'h1);
        tick();
        chk("addi_valid", 64'(out_alu_valid), 64'h1);
        chk("addi_rs2",   out_rs2, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("addi_rd",    64'(out_rd_addr), 64'd4);

        // SRAI x5,x4,2 then SLLI x10,x1,3 with bit 30 set (funct7 must stay 0).
        drive_ok(i_type(12'h402, 5'd4, 3'b101, 5'd5), mk(64'd0, 64'd2, 3'd5, 1'b1, 5'd5));
        tick();
        chk("srai_rs2", out_rs2, 64'd2);
        chk("srai_f7",  64'(out_funct7), 64'h1);
        drive_ok(i_type(12'h403, 5'd1, 3'b001, 5'd10), mk(64'd1, 64'd3, 3'd1, 1'b0, 5'd10));
        tick();
        chk("slli_f7",  64'(out_funct7), 64'h0);
        chk("slli_rs2", out_rs2, 64'd3);
        idle();
        tick();
        chk("drain_valid", 64'(out_alu_valid), 64'h0);

        // RAW hazard: ADD x6 consumed, SUB x7,x6,x1 stalls until x6 writeback.
        drive_ok(r_type(7'b0000000, 5'd2, 5'd1, 3'd0, 5'd6), mk(64'd1, 64'd2, 3'd0, 1'b0, 5'd6));
        tick();
        idle();
        tick();
        drive_ok(r_type(7'b0100000, 5'd1, 5'd6, 3'd0, 5'd7), mk(64'h10, 64'd1, 3'd0, 1'b1, 5'd7));
        for (int i = 0; i < 2; i++) begin
            #1 chk("raw_stall_ready", 64'(out_instr_ready), 64'h0);
            tick();
            chk("raw_stall_valid", 64'(out_alu_valid), 64'h0);
        end
        wb(1'b1, 5'd6, 64'h10);
        #1 chk("raw_wb_ready", 64'(out_instr_ready), 64'h1);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        idle();
        chk("sub_valid", 64'(out_alu_valid), 64'h1);
        chk("sub_rs1",   out_rs1, 64'h10);
        chk("sub_f7",    64'(out_funct7), 64'h1);
        tick();

        // Illegal encodings: load, MUL-style funct7, SUB-form SLL.
        drive_bad(32'h0000_0003);
        tick();
        chk("ill_load_pulse", 64'(out_illegal), 64'h1);
        chk("ill_load_valid", 64'(out_alu_valid), 64'h0);
        idle();
        tick();
        chk("ill_load_end", 64'(out_illegal), 64'h0);
        drive_bad(r_type(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd8));
        tick();
        chk("ill_mul_pulse", 64'(out_illegal), 64'h1);
        chk("ill_mul_valid", 64'(out_alu_valid), 64'h0);
        idle();
        tick();
        chk("ill_mul_end", 64'(out_illegal), 64'h0);
        drive_bad(r_type(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd8));
        tick();
        chk("ill_subsll_pulse", 64'(out_illegal), 64'h1);
        idle();
        tick();

        // Illegal with a pending source (x3) is accepted without stalling.
        drive_bad(r_type(7'b0000001, 5'd1, 5'd3, 3'd0, 5'd9));
        #1 chk("ill_no_stall", 64'(out_instr_ready), 64'h1);
        tick();
        chk("ill_hz_pulse", 64'(out_illegal), 64'h1);
        idle();
        tick();

        // Writeback to x0 is neither stored nor bypassed.
        wb(1'b1, 5'd0, 64'h5);
        drive_ok(r_type(7'b0000000, 5'd0, 5'd0, 3'd0, 5'd9), mk(64'd0, 64'd0, 3'd0, 1'b0, 5'd9));
        tick();
        wb(1'b0, 5'd0, 64'h0);
        idle();
        chk("x0_rs1", out_rs1, 64'h0);
        chk("x0_rs2", out_rs2, 64'h0);
        tick();

        // Reset while FULL with x3 pending.
        in_alu_ready = 1'b0;
        drive_ok(r_type(7'b0000000, 5'd2, 5'd1, 3'd0, 5'd12), mk(64'd1, 64'd2, 3'd0, 1'b0, 5'd12));
        tick();
        idle();
        chk("pre_rst_valid", 64'(out_alu_valid), 64'h1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_alu_valid), 64'h0);
        chk("async_rst_rs1",   out_rs1, 64'h0);
        q.delete();
        @(negedge clk);
        reset        = 1'b0;
        in_alu_ready = 1'b1;
        drive_ok(r_type(7'b0000000, 5'd1, 5'd3, 3'd0, 5'd13), mk(64'd0, 64'd0, 3'd0, 1'b0, 5'd13));
        #1 chk("post_rst_ready", 64'(out_instr_ready), 64'h1);
        tick();
        idle();
        chk("post_rst_valid", 64'(out_alu_valid), 64'h1);
        chk("post_rst_x3",    out_rs1, 64'h0);
        chk("post_rst_x1",    out_rs2, 64'h0);
        tick();
        chk("sb_drained", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_issue.md
ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 Parameter XLEN, default 64, datapath width.
REQ-002 Parameter NREG, default 32, architectural register count (x0..x31).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_instr_valid  input  1  upstream instruction valid.
REQ-006 out_instr_ready  output  1  block accepts in_instr this cycle.
REQ-007 in_instr  input  32  RV64I instruction word.
REQ-008 out_alu_valid  output  1  issued operand bundle valid.
REQ-009 in_alu_ready  input  1  ALU stage consumes the bundle.
REQ-010 out_rs1  output  XLEN  operand A to ALU in_rs1.
REQ-011 out_rs2  output  XLEN  operand B to ALU in_rs2.
REQ-012 out_funct3  output  3  to ALU in_funct3.
REQ-013 out_funct7  output  1  to ALU in_funct7 (instr bit 30 semantics).
REQ-014 out_rd_addr  output  5  destination register tag.
REQ-015 in_wb_valid / in_wb_addr / in_wb_data  input  1/5/XLEN  writeback port.
REQ-016 out_illegal  output  1  one-cycle pulse for a dropped instruction.

Function
REQ-017 The block SHALL contain an NREG x XLEN register file with 2 read ports and 1 write port; x0 SHALL read 0 and writes to x0 SHALL be ignored.
REQ-018 Writeback SHALL write in_wb_data to in_wb_addr at the edge where in_wb_valid=1.
REQ-019 Reads SHALL bypass a same-cycle writeback: rs==in_wb_addr, rs!=0, in_wb_valid=1 -> in_wb_data.
REQ-020 Opcode 0110011 (OP): out_rs2 = regfile[rs2]; out_funct7 = instr[30]; legal only if instr[31:25] is 0000000, or 0100000 with funct3 000/101.
REQ-021 Opcode 0010011 (OP-IMM): out_rs2 = sign-extended instr[31:20]; for funct3 001/101, out_rs2 = zero-extended instr[25:20] and out_funct7 = instr[30] (funct3 101 only), else out_funct7=0.
REQ-022 Any other opcode or illegal encoding SHALL be accepted, not issued, and SHALL pulse out_illegal for exactly one cycle after acceptance.
REQ-023 Output stage SHALL be a two-state FSM: EMPTY (out_alu_valid=0), FULL (out_alu_valid=1); EMPTY->FULL on legal accept; FULL->EMPTY on in_alu_ready with no new accept; FULL->FULL on simultaneous consume and accept.
REQ-024 Latency SHALL be 1 cycle: accept at edge N -> out_alu_valid=1 after edge N.
REQ-025 While FULL and in_alu_ready=0, all out_* bundle signals SHALL hold stable.
REQ-026 A per-register pending bit SHALL be set when a bundle with rd!=0 is consumed and cleared on writeback to that rd; simultaneous set and clear of the same register -> set wins.
REQ-027 out_instr_ready = (EMPTY or in_alu_ready) and no source hazard; hazard = a used source (rs1; rs2 for OP only) has pending=1 and is not being written back this cycle.
REQ-028 Illegal instructions SHALL never stall on hazards.

Reset
REQ-029 reset SHALL asynchronously clear the register file to 0, all pending bits, FSM to EMPTY, out_alu_valid, out_illegal, and all bundle outputs to 0.
REQ-030 reset mid-transaction SHALL discard the held bundle; out_instr_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 Shared package aurora_rv_pkg SHALL hold XLEN, opcode constants (OP, OP_IMM), funct7 constants and the funct3 shift codes.
REQ-032 The register file SHALL be a sub-module regfile_2r1w with x0 hardwiring and the write bypass.

Verification
REQ-033 Write x1=1, x2=2 via wb; issue ADD x3,x1,x2 -> out_rs1=1, out_rs2=2, funct3=0, funct7=0, rd=3 one cycle later.
REQ-034 ADDI x4,x0,-16 -> out_rs1=0, out_rs2=0xFFFF_FFFF_FFFF_FFF0; SRAI x5,x4,2 -> out_rs2=2, out_funct7=1.
REQ-035 Hold in_alu_ready=0 for 3 cycles with bundle FULL -> outputs stable, out_instr_ready=0; release -> next instruction issued the following cycle.
REQ-036 Issue ADD x6 (consumed), then SUB x7,x6,x1 -> stalled until wb x6=0x10; same-cycle wb -> issue with out_rs1=0x10.
REQ-037 Instruction 0x0000_0003 (load) and OP with funct7 0000001 -> out_illegal pulses 1 cycle each, out_alu_valid stays 0.
REQ-038 Assert reset while FULL and x3 pending -> out_alu_valid=0 immediately, pending cleared, x3 reads 0.
